// File: rtl/uart_receiver_mmio.sv
// 8N1 serial receiver with a small receive FIFO and sticky error flags,
// presented to the SOC IO page as head byte, valid, fill count and errors.
module uart_receiver_mmio #(
   parameter int CLK_FREQ_HZ = 12000000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          i_rxd,
   input  logic                          i_rx_pop,
   input  logic                          i_clr_err,
   output logic [7:0]                    o_rx_data,
   output logic                          o_rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]   o_rx_count,
   output logic                          o_overrun,
   output logic                          o_frame_err,
   output logic [1:0]                    o_state
);

   localparam int DIVISOR = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CNT_W   = $clog2(DIVISOR);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_FW  = PTR_W + 1;

   localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(DIVISOR / 2 - 1);
   localparam logic [CNT_W-1:0]  FULL_LOAD = CNT_W'(DIVISOR - 1);
   localparam logic [CNT_FW-1:0] FULL_CNT  = CNT_FW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;

   logic              rxd_m;
   logic              rxd_s;
   logic              rxd_p;
   logic              start_det;

   logic [CNT_W-1:0]  cnt;
   logic              cnt_zero;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;

   logic              load_half;
   logic              load_full;
   logic              shift_en;
   logic              push_req;
   logic              frame_set;

   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_FW-1:0] count;
   logic              full;
   logic              pop_eff;
   logic              push_ok;
   logic              overrun_set;

   // Synchronizer resets high so a line idling high never looks like a start edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
         rxd_p <= 1'b1;
      end else begin
         rxd_m <= i_rxd;
         rxd_s <= rxd_m;
         rxd_p <= rxd_s;
      end
   end

   // Only a falling edge starts a frame, so a line stuck low (break) stays idle.
   assign start_det = rxd_p & ~rxd_s;
   assign cnt_zero  = (cnt == '0);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start_det) state_nx = S_START;
         end
         S_START: begin
            if (cnt_zero) state_nx = rxd_s ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (cnt_zero && (bit_idx == 3'd7)) state_nx = S_STOP;
         end
         S_STOP: begin
            if (cnt_zero) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      load_half = 1'b0;
      load_full = 1'b0;
      shift_en  = 1'b0;
      push_req  = 1'b0;
      frame_set = 1'b0;
      case (state)
         S_IDLE: begin
            load_half = start_det;
         end
         S_START: begin
            load_full = cnt_zero & ~rxd_s;
         end
         S_DATA: begin
            shift_en  = cnt_zero;
            load_full = cnt_zero;
         end
         S_STOP: begin
            push_req  = cnt_zero & rxd_s;
            frame_set = cnt_zero & ~rxd_s;
         end
         default: begin
            load_half = 1'b0;
         end
      endcase
   end

   // Bit timer: half a bit to reach mid start bit, then whole bits.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         if (load_half) begin
            cnt <= HALF_LOAD;
         end else if (load_full) begin
            cnt <= FULL_LOAD;
         end else if ((state != S_IDLE) && !cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
         end

         if (state == S_START) begin
            bit_idx <= '0;
         end else if (shift_en) begin
            bit_idx <= bit_idx + 3'd1;
         end

         if (shift_en) begin
            shreg <= {rxd_s, shreg[7:1]};
         end
      end
   end

   assign full        = (count == FULL_CNT);
   assign pop_eff     = i_rx_pop & (count != '0);
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok     = push_req & (~full | pop_eff);
   assign overrun_set = push_req & full & ~pop_eff;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= shreg;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_eff) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_eff})
            2'b10:   count <= count + CNT_FW'(1);
            2'b01:   count <= count - CNT_FW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky flags: a set in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         o_overrun   <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_overrun   <= overrun_set | (o_overrun & ~i_clr_err);
         o_frame_err <= frame_set | (o_frame_err & ~i_clr_err);
      end
   end

   assign o_rx_data  = mem[rd_ptr];
   assign o_rx_valid = (count != '0);
   assign o_rx_count = count;
   assign o_state    = state;

endmodule
